npc_predict: RTL
================

// Module: npc_predict
// PURPOSE
//   Parametrised next-PC unit with a branch target buffer (BTB) and branch statistics.
//   Fetch side: combinational lookup of if_pc gives the predicted next fetch PC.
//   EX side: resolves jr/j/jal/beq/bne/regimm, detects mispredicts, drives the
//   redirect (newpc, pcclear) and trains the BTB.
// PARAMETERS
//   ADDR_W     32  PC width in bits.
//   BTB_DEPTH  64  BTB entry count; power of 2. IDX_W = log2(BTB_DEPTH).
//   CNT_W      16  Statistics counter width.
// PORTS
//   clk            in   1       Clock; all state updates on the rising edge.
//   clear          in   1       Reset: synchronous, active-high.
//   pcen           in   1       Pipeline advance; gates redirect, training and counters.
//   if_pc          in   ADDR_W  Fetch-stage PC.
//   pred_pc        out  ADDR_W  Predicted next fetch PC.
//   pred_taken     out  1       BTB hit with counter bit 1 set.
//   ex_valid       in   1       EX stage holds a valid instruction.
//   ex_op          in   6       EX opcode.
//   ex_funct       in   6       EX funct field.
//   ex_pc          in   ADDR_W  EX instruction PC.
//   ex_pred_pc     in   ADDR_W  pred_pc carried down the pipe with this instruction.
//   ex_aluout      in   32      Branch compare result from the ALU.
//   ex_label       in   26      Instruction bits [25:0].
//   ex_rfd1        in   32      rs register value (jr target).
//   newpc          out  ADDR_W  Next PC to load.
//   pcclear        out  1       Flush/redirect request.
//   uncondsum      out  CNT_W   Count of resolved unconditional jumps.
//   condsum        out  CNT_W   Count of resolved conditional branches.
//   condsuccsum    out  CNT_W   Count of conditional branches taken.
//   mispredsum     out  CNT_W   Count of mispredicts.
// BEHAVIOUR
//   Entry fields: valid, tag = pc[ADDR_W-1:IDX_W+2], target, ctr[1:0]. Index = pc[IDX_W+1:2].
//   Lookup (combinational): hit && ctr[1] -> pred_pc = target, pred_taken = 1.
//     Otherwise pred_pc = if_pc+4 and pred_taken = 0.
//   Resolve (combinational):
//     jr  = op 00 && funct 08; target = ex_rfd1.
//     j/jal = op 02 / 03; target = {ex_pc[31:28], ex_label, 2'b00}.
//     beq (op 04) taken when aluout == 0; bne (op 05) taken when aluout != 0.
//     regimm (op 01) taken when aluout == 1.
//     Branch target = ex_pc + 4 + (sext(ex_label[15:0]) << 2).
//     Unconditional instructions are always taken. actual = taken ? target : ex_pc+4.
//   Redirect: pcclear = ex_valid && pcen && (ex_pred_pc != actual).
//     When pcclear = 1: newpc = actual. Otherwise newpc = pred_pc.
//     Zero-cycle latency; the EX redirect has priority over the fetch prediction.
//   Training at the clock edge when ex_valid && pcen:
//     taken j/jal: write entry, ctr = 11.
//     taken branch, hit: target updated, ctr incremented with saturation.
//     taken branch, miss: allocate the entry, ctr = 10.
//     not-taken branch, hit: ctr decremented with saturation at 00.
//     not-taken branch, miss: no write.
//     jr: never allocated.
//     Any other opcode: no write.
//   Same-cycle lookup and update of the same index: the lookup sees the pre-edge contents.
//   Counters increment when ex_valid && pcen and the event applies; they wrap modulo 2^CNT_W.
//   clear: on the next edge all valid bits = 0 and all counters = 0.
//     Outputs then read pred_pc = if_pc+4, pred_taken = 0.
//     pcclear follows the inputs (pcclear = 0 when ex_valid = 0).
//     clear overrides any training or count in the same cycle.
//   pcen = 0: no redirect, no BTB write, counters hold.
// CONFIGURATION
//   NPC_PERF_EN defined: the four statistics counters are built.
//   NPC_PERF_EN undefined: counter logic is removed, the four sum outputs are tied to 0,
//   and the ports are kept.
// STRUCTURE
//   Package npc_pkg holds:
//     OP_SPECIAL, FN_JR, OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE;
//     CTR_SNT = 00, CTR_WNT = 01, CTR_WT = 10, CTR_ST = 11;
//     the btb_entry_t layout.
//   Sub-module npc_btb: storage, lookup and saturating update.
//   Statistics use the existing counter module.
// TESTING
//   Reset: clear = 1 for 1 cycle, if_pc = 0x3000 -> pred_pc = 0x3004, pred_taken = 0, all sums 0.
//   Cold beq: ex_pc = 0x3010, label[15:0] = 0x0004, aluout = 0, ex_pred_pc = 0x3014
//     -> newpc = 0x3024, pcclear = 1;
//     then if_pc = 0x3010 -> pred_pc = 0x3024, pred_taken = 1;
//     condsum = 1, condsuccsum = 1, mispredsum = 1.
//   Training down: bne not taken twice at 0x3010 (ctr 10 -> 01 -> 00)
//     -> after the first, pred_pc = 0x3014;
//     the first also gives pcclear = 1 with newpc = 0x3014.
//   jr: op 00, funct 08, rfd1 = 0x3400 -> newpc = 0x3400, pcclear = 1, uncondsum + 1;
//     later lookup at ex_pc misses.
//   Stall: the cold-beq mispredict inputs with pcen = 0 -> pcclear = 0, no BTB write, sums unchanged.
//   Aliasing, BTB_DEPTH = 4: j at 0x3000 trained; lookup at 0x3010 (same index, other tag)
//     -> pred_pc = 0x3014. CNT_W = 4: 16 jumps -> uncondsum wraps to 0.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared opcode constants, BTB counter encoding and entry layout for the next-PC unit.
package npc_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  // Tag and target are held at full 32-bit width; narrower PCs zero-extend.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    ctr_t        ctr;
  } btb_entry_t;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'b01);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'b01);
  endfunction

endpackage

// File: rtl/npc_btb.sv
// Direct-mapped branch target buffer: combinational lookup, 2-bit saturating training.
module npc_btb
  import npc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BTB_DEPTH = 64
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              hit_taken,
  output logic [ADDR_W-1:0] hit_target,
  input  logic              upd_en,
  input  logic              upd_uncond,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target
);

  localparam int unsigned IDX_W = $clog2(BTB_DEPTH);

  btb_entry_t mem [BTB_DEPTH];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [31:0]      rd_tag, wr_tag;
  btb_entry_t       rd_e, wr_e;
  logic             wr_hit;

  // Lookup and update-side hit detection; both read pre-edge contents.
  always_comb begin
    rd_idx     = lookup_pc[IDX_W+1:2];
    rd_tag     = 32'(lookup_pc >> (IDX_W + 2));
    rd_e       = mem[rd_idx];
    hit_taken  = rd_e.valid && (rd_e.tag == rd_tag) && rd_e.ctr[1];
    hit_target = ADDR_W'(rd_e.target);
    wr_idx     = upd_pc[IDX_W+1:2];
    wr_tag     = 32'(upd_pc >> (IDX_W + 2));
    wr_e       = mem[wr_idx];
    wr_hit     = wr_e.valid && (wr_e.tag == wr_tag);
  end

  // Invalidate on clear; otherwise train the indexed entry.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < BTB_DEPTH; i++) mem[IDX_W'(i)].valid <= 1'b0;
    end else if (upd_en) begin
      if (upd_uncond) begin
        mem[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: 32'(upd_target), ctr: CTR_ST};
      end else if (upd_taken) begin
        if (wr_hit) begin
          mem[wr_idx].target <= 32'(upd_target);
          mem[wr_idx].ctr    <= ctr_inc(wr_e.ctr);
        end else begin
          mem[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: 32'(upd_target), ctr: CTR_WT};
        end
      end else if (wr_hit) begin
        mem[wr_idx].ctr <= ctr_dec(wr_e.ctr);
      end
    end
  end

endmodule

// File: rtl/npc_counter.sv
// Wrapping event counter with synchronous clear.
module npc_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled events; clear has priority.
  always_ff @(posedge clk) begin
    if (clear)   count <= '0;
    else if (en) count <= count + 1'b1;
  end

endmodule

// File: rtl/npc_predict.sv
// Next-PC unit: BTB fetch prediction, EX-stage branch resolve/redirect, statistics.
// Statistics counters are built only when NPC_PERF_EN is defined.
module npc_predict
  import npc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BTB_DEPTH = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              pcen,
  input  logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] pred_pc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic [5:0]        ex_op,
  input  logic [5:0]        ex_funct,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_pred_pc,
  input  logic [31:0]       ex_aluout,
  input  logic [25:0]       ex_label,
  input  logic [31:0]       ex_rfd1,
  output logic [ADDR_W-1:0] newpc,
  output logic              pcclear,
  output logic [CNT_W-1:0]  uncondsum,
  output logic [CNT_W-1:0]  condsum,
  output logic [CNT_W-1:0]  condsuccsum,
  output logic [CNT_W-1:0]  mispredsum
);

  logic              hit_taken;
  logic [ADDR_W-1:0] hit_target;
  logic              is_jr, is_j, is_cond, cond_taken, taken, go;
  logic [ADDR_W-1:0] seq_pc, target, actual;
  logic [31:0]       pc32;

  npc_btb #(.ADDR_W(ADDR_W), .BTB_DEPTH(BTB_DEPTH)) u_btb (
    .clk        (clk),
    .clear      (clear),
    .lookup_pc  (if_pc),
    .hit_taken  (hit_taken),
    .hit_target (hit_target),
    .upd_en     (go && (is_j || is_cond)),
    .upd_uncond (is_j),
    .upd_taken  (is_j || cond_taken),
    .upd_pc     (ex_pc),
    .upd_target (target)
  );

  // Decode, resolve and redirect; EX redirect overrides the fetch prediction.
  always_comb begin
    pred_taken = hit_taken;
    pred_pc    = hit_taken ? hit_target : if_pc + ADDR_W'(4);
    pc32       = 32'(ex_pc);
    seq_pc     = ex_pc + ADDR_W'(4);
    is_jr      = (ex_op == OP_SPECIAL) && (ex_funct == FN_JR);
    is_j       = (ex_op == OP_J) || (ex_op == OP_JAL);
    is_cond    = (ex_op == OP_BEQ) || (ex_op == OP_BNE) || (ex_op == OP_REGIMM);
    cond_taken = ((ex_op == OP_BEQ)    && (ex_aluout == 32'd0)) ||
                 ((ex_op == OP_BNE)    && (ex_aluout != 32'd0)) ||
                 ((ex_op == OP_REGIMM) && (ex_aluout == 32'd1));
    taken      = is_jr || is_j || cond_taken;
    if (is_jr)     target = ADDR_W'(ex_rfd1);
    else if (is_j) target = ADDR_W'((pc32 & 32'hF000_0000) | {4'b0, ex_label, 2'b00});
    else           target = seq_pc + ADDR_W'({{14{ex_label[15]}}, ex_label[15:0], 2'b00});
    actual     = taken ? target : seq_pc;
    go         = ex_valid && pcen;
    pcclear    = go && (ex_pred_pc != actual);
    newpc      = pcclear ? actual : pred_pc;
  end

`ifdef NPC_PERF_EN
  npc_counter #(.W(CNT_W)) u_uncond (
    .clk(clk), .clear(clear), .en(go && (is_j || is_jr)), .count(uncondsum));
  npc_counter #(.W(CNT_W)) u_cond (
    .clk(clk), .clear(clear), .en(go && is_cond), .count(condsum));
  npc_counter #(.W(CNT_W)) u_condsucc (
    .clk(clk), .clear(clear), .en(go && cond_taken), .count(condsuccsum));
  npc_counter #(.W(CNT_W)) u_mispred (
    .clk(clk), .clear(clear), .en(pcclear), .count(mispredsum));
`else
  assign uncondsum   = '0;
  assign condsum     = '0;
  assign condsuccsum = '0;
  assign mispredsum  = '0;
`endif

endmodule
